// File: rtl/spc_stack_if.sv
// Bus bundle for the subroutine return stack: push/pop/load controls
// from the microsequencer and the stack status returned to it.
interface spc_stack_if #(
    parameter int WIDTH = 19,
    parameter int AW    = 5
);
    logic             push;
    logic             pop;
    logic [WIDTH-1:0] din;
    logic             load_n;
    logic [AW-1:0]    ptr_in;
    logic             clr_err;
    logic [WIDTH-1:0] dout;
    logic [AW-1:0]    sptr;
    logic [AW:0]      cnt;
    logic             empty;
    logic             full;
    logic             ovf;
    logic             unf;

    modport master (
        output push, pop, din, load_n, ptr_in, clr_err,
        input  dout, sptr, cnt, empty, full, ovf, unf
    );

    modport slave (
        input  push, pop, din, load_n, ptr_in, clr_err,
        output dout, sptr, cnt, empty, full, ovf, unf
    );
endinterface

// File: rtl/spc_stack.sv
// Subroutine-PC return stack: wrapping pointer into a small register-file
// RAM, saturating occupancy count and sticky overflow/underflow flags.
module spc_stack #(
    parameter int WIDTH = 19,
    parameter int AW    = 5
) (
    input  logic        clk,
    input  logic        rst_n,
    spc_stack_if.slave  bus
);
    localparam int          DEPTH    = 2 ** AW;
    localparam logic [AW:0] CNT_FULL = (AW + 1)'(DEPTH);

    typedef enum logic [2:0] {
        OP_IDLE,
        OP_LOAD,
        OP_PUSH,
        OP_POP,
        OP_REPLACE
    } op_t;

    op_t              op;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    sptr, sptr_next, waddr;
    logic [AW:0]      cnt, cnt_next;
    logic             ovf, unf, ovf_next, unf_next;
    logic             empty, full, we;

    assign empty = (cnt == '0);
    assign full  = (cnt == CNT_FULL);

    // A simultaneous push and pop on an empty stack has nothing to replace,
    // so it degrades to an ordinary push.
    always_comb begin
        op = OP_IDLE;
        if (!bus.load_n)
            op = OP_LOAD;
        else if (bus.push && bus.pop)
            op = empty ? OP_PUSH : OP_REPLACE;
        else if (bus.push)
            op = OP_PUSH;
        else if (bus.pop)
            op = OP_POP;
    end

    always_comb begin
        sptr_next = sptr;
        cnt_next  = cnt;
        ovf_next  = bus.clr_err ? 1'b0 : ovf;
        unf_next  = bus.clr_err ? 1'b0 : unf;
        we        = 1'b0;
        waddr     = sptr;
        case (op)
            OP_LOAD: sptr_next = bus.ptr_in;
            OP_PUSH: begin
                we        = 1'b1;
                waddr     = sptr + 1'b1;
                sptr_next = sptr + 1'b1;
                if (full)
                    ovf_next = 1'b1;
                else
                    cnt_next = cnt + 1'b1;
            end
            OP_POP: begin
                sptr_next = sptr - 1'b1;
                if (empty)
                    unf_next = 1'b1;
                else
                    cnt_next = cnt - 1'b1;
            end
            OP_REPLACE: we = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sptr <= '0;
            cnt  <= '0;
            ovf  <= 1'b0;
            unf  <= 1'b0;
        end else begin
            sptr <= sptr_next;
            cnt  <= cnt_next;
            ovf  <= ovf_next;
            unf  <= unf_next;
        end
    end

    // RAM contents survive reset; writes are simply blocked while it is held.
    always_ff @(posedge clk) begin
        if (rst_n && we)
            mem[waddr] <= bus.din;
    end

    assign bus.dout  = empty ? '0 : mem[sptr];
    assign bus.sptr  = sptr;
    assign bus.cnt   = cnt;
    assign bus.empty = empty;
    assign bus.full  = full;
    assign bus.ovf   = ovf;
    assign bus.unf   = unf;
endmodule

// File: tb/tb_spc_stack.sv
// Bench for spc_stack: directed scenarios plus randomized traffic checked
// against an array-based model of the return stack.
module tb_spc_stack;
    localparam int WIDTH = 19;
    localparam int AW    = 5;
    localparam int DEPTH = 32;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    spc_stack_if #(.WIDTH(WIDTH), .AW(AW)) bus ();
    spc_stack #(.WIDTH(WIDTH), .AW(AW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    int compared   = 0;
    int mismatched = 0;

    logic [WIDTH-1:0] m_mem [DEPTH];
    int               m_sptr;
    int               m_cnt;
    logic             m_ovf;
    logic             m_unf;

    function automatic void model_reset();
        m_sptr = 0;
        m_cnt  = 0;
        m_ovf  = 1'b0;
        m_unf  = 1'b0;
    endfunction

    function automatic void model_update(logic p, logic po, logic [WIDTH-1:0] d,
                                         logic ld_n, logic [AW-1:0] pi, logic clr);
        if (clr) begin
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end
        if (!ld_n)
            m_sptr = int'(pi);
        else if (p && (!po || m_cnt == 0)) begin
            m_sptr = (m_sptr + 1) % DEPTH;
            m_mem[m_sptr] = d;
            if (m_cnt == DEPTH) m_ovf = 1'b1;
            else                m_cnt = m_cnt + 1;
        end else if (p)
            m_mem[m_sptr] = d;
        else if (po) begin
            m_sptr = (m_sptr + DEPTH - 1) % DEPTH;
            if (m_cnt == 0) m_unf = 1'b1;
            else            m_cnt = m_cnt - 1;
        end
    endfunction

    function automatic logic [33:0] expected_vec();
        logic [WIDTH-1:0] top;
        top = (m_cnt == 0) ? '0 : m_mem[m_sptr];
        return {top, 5'(m_sptr), 6'(m_cnt), m_cnt == 0, m_cnt == DEPTH, m_ovf, m_unf};
    endfunction

    function automatic logic [33:0] observed_vec();
        return {bus.dout, bus.sptr, bus.cnt, bus.empty, bus.full, bus.ovf, bus.unf};
    endfunction

    task automatic idle_inputs();
        bus.push    = 1'b0;
        bus.pop     = 1'b0;
        bus.din     = '0;
        bus.load_n  = 1'b1;
        bus.ptr_in  = '0;
        bus.clr_err = 1'b0;
    endtask

    task automatic step(input logic p, input logic po, input logic [WIDTH-1:0] d,
                        input logic ld_n, input logic [AW-1:0] pi, input logic clr);
        bus.push    = p;
        bus.pop     = po;
        bus.din     = d;
        bus.load_n  = ld_n;
        bus.ptr_in  = pi;
        bus.clr_err = clr;
        @(posedge clk);
        model_update(p, po, d, ld_n, pi, clr);
        #1;
        idle_inputs();
    endtask

    task automatic apply_reset();
        @(posedge clk);
        #2 rst_n = 1'b0;
        #2 rst_n = 1'b1;
        model_reset();
    endtask

    task automatic applyStimulus_unused_guard();
    endtask

    task automatic test_reset();
        idle_inputs();
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        model_reset();
        compared++;
        if (observed_vec() !== {19'd0, 5'd0, 6'd0, 4'b1000}) begin
            mismatched++;
            $display("[TB] FAIL reset_async: got %h expected %h", observed_vec(), {19'd0, 5'd0, 6'd0, 4'b1000});
        end
        bus.push = 1'b1;
        bus.din  = 19'h1234;
        repeat (2) @(posedge clk);
        #1;
        compared++;
        if (observed_vec() !== {19'd0, 5'd0, 6'd0, 4'b1000}) begin
            mismatched++;
            $display("[TB] FAIL reset_push_held: got %h expected %h", observed_vec(), {19'd0, 5'd0, 6'd0, 4'b1000});
        end
        idle_inputs();
        rst_n = 1'b1;
        step(1'b0, 1'b0, '0, 1'b1, '0, 1'b0);
        compared++;
        if (observed_vec() !== expected_vec()) begin
            mismatched++;
            $display("[TB] FAIL reset_idle: got %h expected %h", observed_vec(), expected_vec());
        end
    endtask

    task automatic test_push_pop();
        logic [WIDTH-1:0] vals [3];
        vals[0] = 19'h1A; vals[1] = 19'h2B; vals[2] = 19'h3C;
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0, vals[i], 1'b1, '0, 1'b0);
            compared++;
            if (bus.sptr !== 5'(i + 1) || observed_vec() !== expected_vec()) begin
                mismatched++;
                $display("[TB] FAIL push_%0d: got sptr=%0d vec=%h expected sptr=%0d vec=%h",
                         i, bus.sptr, observed_vec(), i + 1, expected_vec());
            end
        end
        for (int i = 0; i < 3; i++) begin
            compared++;
            if (bus.dout !== vals[2-i]) begin
                mismatched++;
                $display("[TB] FAIL top_before_pop_%0d: got %h expected %h", i, bus.dout, vals[2-i]);
            end
            step(1'b0, 1'b1, '0, 1'b1, '0, 1'b0);
            compared++;
            if (bus.sptr !== 5'(2 - i)) begin
                mismatched++;
                $display("[TB] FAIL pop_sptr_%0d: got %0d expected %0d", i, bus.sptr, 2 - i);
            end
        end
        compared++;
        if (observed_vec() !== {19'd0, 5'd0, 6'd0, 4'b1000}) begin
            mismatched++;
            $display("[TB] FAIL drained: got %h expected %h", observed_vec(), {19'd0, 5'd0, 6'd0, 4'b1000});
        end
    endtask

    task automatic test_overflow();
        for (int k = 1; k <= DEPTH; k++)
            step(1'b1, 1'b0, 19'(19'h100 + k), 1'b1, '0, 1'b0);
        compared++;
        if ({bus.full, bus.cnt, bus.sptr} !== {1'b1, 6'd32, 5'd0}) begin
            mismatched++;
            $display("[TB] FAIL fill32: got full=%b cnt=%0d sptr=%0d expected full=1 cnt=32 sptr=0",
                     bus.full, bus.cnt, bus.sptr);
        end
        step(1'b1, 1'b0, 19'h7FFFF, 1'b1, '0, 1'b0);
        compared++;
        if ({bus.ovf, bus.cnt, bus.sptr, bus.dout} !== {1'b1, 6'd32, 5'd1, 19'h7FFFF}) begin
            mismatched++;
            $display("[TB] FAIL overflow_push: got ovf=%b cnt=%0d sptr=%0d dout=%h expected ovf=1 cnt=32 sptr=1 dout=7ffff",
                     bus.ovf, bus.cnt, bus.sptr, bus.dout);
        end
        step(1'b0, 1'b0, '0, 1'b1, '0, 1'b1);
        compared++;
        if (bus.ovf !== 1'b0 || observed_vec() !== expected_vec()) begin
            mismatched++;
            $display("[TB] FAIL clr_ovf: got %h expected %h", observed_vec(), expected_vec());
        end
    endtask

    task automatic test_underflow();
        apply_reset();
        step(1'b0, 1'b1, '0, 1'b1, '0, 1'b0);
        compared++;
        if ({bus.unf, bus.sptr, bus.cnt, bus.dout} !== {1'b1, 5'd31, 6'd0, 19'd0}) begin
            mismatched++;
            $display("[TB] FAIL pop_empty: got unf=%b sptr=%0d cnt=%0d dout=%h expected unf=1 sptr=31 cnt=0 dout=0",
                     bus.unf, bus.sptr, bus.cnt, bus.dout);
        end
        step(1'b1, 1'b1, 19'h55, 1'b1, '0, 1'b0);
        compared++;
        if ({bus.sptr, bus.cnt, bus.dout, bus.unf} !== {5'd0, 6'd1, 19'h55, 1'b1}) begin
            mismatched++;
            $display("[TB] FAIL pushpop_empty: got sptr=%0d cnt=%0d dout=%h unf=%b expected sptr=0 cnt=1 dout=55 unf=1",
                     bus.sptr, bus.cnt, bus.dout, bus.unf);
        end
    endtask

    task automatic test_replace();
        apply_reset();
        step(1'b1, 1'b0, 19'h11, 1'b1, '0, 1'b0);
        step(1'b1, 1'b0, 19'h22, 1'b1, '0, 1'b0);
        step(1'b1, 1'b1, 19'h44, 1'b1, '0, 1'b0);
        compared++;
        if ({bus.sptr, bus.cnt, bus.dout, bus.ovf, bus.unf} !== {5'd2, 6'd2, 19'h44, 2'b00}) begin
            mismatched++;
            $display("[TB] FAIL replace_top: got sptr=%0d cnt=%0d dout=%h expected sptr=2 cnt=2 dout=44",
                     bus.sptr, bus.cnt, bus.dout);
        end
        step(1'b0, 1'b1, '0, 1'b1, '0, 1'b0);
        compared++;
        if ({bus.sptr, bus.dout} !== {5'd1, 19'h11}) begin
            mismatched++;
            $display("[TB] FAIL pop_after_replace: got sptr=%0d dout=%h expected sptr=1 dout=11",
                     bus.sptr, bus.dout);
        end
    endtask

    task automatic test_load();
        step(1'b1, 1'b0, 19'h666, 1'b0, 5'd9, 1'b0);
        compared++;
        if ({bus.sptr, bus.cnt, bus.dout} !== {5'd9, 6'd1, 19'h109}) begin
            mismatched++;
            $display("[TB] FAIL load9: got sptr=%0d cnt=%0d dout=%h expected sptr=9 cnt=1 dout=109",
                     bus.sptr, bus.cnt, bus.dout);
        end
        step(1'b0, 1'b0, '0, 1'b0, 5'd10, 1'b0);
        compared++;
        if ({bus.sptr, bus.dout} !== {5'd10, 19'h10A} || observed_vec() !== expected_vec()) begin
            mismatched++;
            $display("[TB] FAIL load10_intact: got sptr=%0d dout=%h expected sptr=10 dout=10a",
                     bus.sptr, bus.dout);
        end
    endtask

    task automatic test_random();
        int bias;
        logic p, po, ld_n, clr;
        for (int i = 0; i < 600; i++) begin
            bias = ((i / 120) % 2 == 0) ? 60 : 35;
            p    = ($urandom_range(0, 99) < bias);
            po   = ($urandom_range(0, 99) < (100 - bias));
            ld_n = ($urandom_range(0, 39) != 0);
            clr  = ($urandom_range(0, 9) == 0);
            step(p, po, WIDTH'($urandom), ld_n, AW'($urandom), clr);
            compared++;
            if (observed_vec() !== expected_vec()) begin
                mismatched++;
                $display("[TB] FAIL random_%0d: got %h expected %h", i, observed_vec(), expected_vec());
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
        model_reset();
        idle_inputs();
        test_reset();
        test_push_pop();
        test_overflow();
        test_underflow();
        test_replace();
        test_load();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/spc_stack.md
Name: spc_stack

Overview:
- Subroutine-PC return stack for the microsequencer.
- Its stack pointer is an up/down counter with load, and it consumes that pointer to address a small register-file RAM.
- Supports push on call and pop on return, plus a diagnostic pointer load.
- Tracks occupancy and provides sticky overflow/underflow flags for the error/status logic.

Parameters:
- WIDTH, 19, width of each stacked return address.
- AW, 5, pointer width; depth is 2**AW = 32 entries.

Ports:
- CLK  input  1  single clock; all state changes on rising edge.
- RESET_N  input  1  asynchronous, active-low reset.
- PUSH  input  1  push DIN this cycle.
- POP  input  1  pop top entry this cycle.
- DIN  input  WIDTH  return address to push.
- LOAD_N  input  1  active-low synchronous pointer load (diagnostic).
- PTR_IN  input  AW  value for pointer load.
- CLR_ERR  input  1  synchronous clear of OVF/UNF.
- DOUT  output  WIDTH  top-of-stack; combinational read of mem[SPTR], forced 0 when EMPTY.
- SPTR  output  AW  current pointer; indexes the top entry.
- CNT  output  AW+1  valid entries, 0..2**AW.
- EMPTY  output  1  CNT==0.
- FULL  output  1  CNT==2**AW.
- OVF  output  1  sticky: push attempted while FULL.
- UNF  output  1  sticky: pop attempted while EMPTY.

Behaviour:
- Clock and reset: one clock (CLK). Reset is asynchronous and active-low (RESET_N).
- Reset values: SPTR=0, CNT=0, OVF=0, UNF=0. Reset does not clear RAM contents. DOUT=0 because EMPTY=1.
- Reset asserted mid-operation aborts any push/pop that cycle; no RAM write occurs while RESET_N is low.
- Priority per edge: LOAD_N low, then PUSH&POP, then PUSH, then POP, then idle.
- Load (LOAD_N=0): SPTR<=PTR_IN. CNT, flags and RAM are unchanged. PUSH and POP are ignored that cycle.
- Push only: mem[SPTR+1]<=DIN, SPTR<=SPTR+1 (mod 2**AW), CNT<=CNT+1.
- Push while FULL: the write and pointer wrap still occur, overwriting the oldest entry. CNT stays 2**AW and OVF<=1.
- Pop only: SPTR<=SPTR-1 (mod 2**AW), CNT<=CNT-1.
- Pop while EMPTY: SPTR still decrements (wraps 0 to 2**AW-1) and CNT stays 0. UNF<=1, with no RAM write.
- PUSH&POP together, not EMPTY: replace top. mem[SPTR]<=DIN; SPTR and CNT are unchanged; no flag change.
- PUSH&POP together while EMPTY: behaves as a plain push; UNF is not set.
- Read timing: DOUT is combinational from the current SPTR. After a push, DOUT equals the pushed DIN from the following cycle on (zero read latency, one-cycle write-to-read).
- CLR_ERR: OVF<=0 and UNF<=0. If a new overflow/underflow occurs in the same cycle, set wins.
- Arithmetic: pointer arithmetic is modulo 2**AW. CNT saturates at 0 and 2**AW and never wraps.
- EMPTY and FULL are decoded combinationally from CNT.

Test Plan:
- Reset then idle: RESET_N low mid-cycle -> immediately SPTR=0, CNT=0, EMPTY=1, FULL=0, DOUT=0, OVF=UNF=0. Repeat with a PUSH asserted during reset -> no state change.
- Push 0x1A, 0x2B, 0x3C, then pop ×3 -> SPTR 1,2,3 then 2,1,0. DOUT shows 0x3C, 0x2B, 0x1A before each pop respectively. Ends EMPTY=1, DOUT=0, no flags.
- Push 32 distinct values -> FULL=1, CNT=32, SPTR=0. A 33rd push of 0x7FFFF -> OVF=1, CNT=32, SPTR=1, DOUT=0x7FFFF. A CLR_ERR pulse then clears OVF.
- Pop on EMPTY -> UNF=1, SPTR=31, CNT=0, DOUT=0. Then PUSH&POP with DIN=0x55 -> treated as push: SPTR=0, CNT=1, DOUT=0x55, UNF still 1.
- With 2 entries (top 0x22), PUSH&POP with DIN=0x44 -> SPTR and CNT unchanged, DOUT=0x44. A following pop shows the previous entry.
- LOAD_N=0, PTR_IN=9, with PUSH=1 same cycle -> SPTR=9, CNT unchanged, no RAM write: the old mem[10] is intact after a subsequent PUSH&POP-free read via load to 10.
